restart_control: RTL and testbench

RESTART_CONTROL -- requirements
Module: restart_control

---
 rtl/restart_control.sv | 167 ++++++++++++++++
 tb/tb_restart_control.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/restart_control.sv
// restart_control: drives the PSL RESTART sequence after a PAGED response.
//
// A PAGED response (while enabled) blocks upstream issue, and every PAGED/FLUSHED
// tag seen from then on is queued. Once the command tracker drains, a single
// RESTART command is issued (retried on any non-DONE answer). After DONE, the
// queued tags are streamed out for reissue, then the block returns to idle.
//
// Ports:
//   clock, rstn                  clock, asynchronous active-low reset
//   enabled_in                   job running; gates only the start of a sequence
//   response_valid_in/_tag_in/_code_in   PSL response, one cycle each
//   outstanding_count_in         commands in flight (excluding RESTART)
//   command_credit_in            a PSL command credit is available this cycle
//   restart_valid_out/_command_out/_tag_out   RESTART issue strobe and fields
//   command_block_out            upstream arbiter must hold off new commands
//   replay_valid_out/_tag_out, replay_ready_in   stream of tags to reissue
//   restart_error_out            sticky: [0] replay overflow, [1] RESTART not DONE
module restart_control #(
  parameter logic [7:0]  RESTART_TAG    = 8'hFF,
  parameter int unsigned REPLAY_DEPTH   = 32,
  parameter logic [12:0] RESTART_OPCODE = 13'h0001
) (
  input  logic        clock,
  input  logic        rstn,
  input  logic        enabled_in,
  input  logic        response_valid_in,
  input  logic [7:0]  response_tag_in,
  input  logic [7:0]  response_code_in,
  input  logic [7:0]  outstanding_count_in,
  input  logic        command_credit_in,
  output logic        restart_valid_out,
  output logic [12:0] restart_command_out,
  output logic [7:0]  restart_tag_out,
  output logic        command_block_out,
  output logic        replay_valid_out,
  output logic [7:0]  replay_tag_out,
  input  logic        replay_ready_in,
  output logic [1:0]  restart_error_out
);

  localparam int unsigned AW = $clog2(REPLAY_DEPTH);
  localparam logic [AW:0] FullCnt = REPLAY_DEPTH[AW:0];

  localparam logic [7:0] CodeDone    = 8'h00;
  localparam logic [7:0] CodeFlushed = 8'h06;
  localparam logic [7:0] CodePaged   = 8'h0A;

  typedef enum logic [2:0] {StIdle, StDrain, StIssue, StWait, StReplay} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    err_q, err_d;
  logic          block_q;
  logic [7:0]    mem_q [REPLAY_DEPTH];

  logic is_restart_rsp, is_paged, is_flushed;
  logic push_req, push_ok, pop, full, empty, overflow;
  logic restart_issue;

  // RESTART_TAG responses never count as normal traffic.
  assign is_restart_rsp = response_valid_in && (response_tag_in == RESTART_TAG);
  assign is_paged   = response_valid_in && (response_tag_in != RESTART_TAG) &&
                      (response_code_in == CodePaged);
  assign is_flushed = response_valid_in && (response_tag_in != RESTART_TAG) &&
                      (response_code_in == CodeFlushed);

  // Idle only reacts to PAGED (and only when enabled); replay only re-enters on PAGED.
  always_comb begin
    push_req = 1'b0;
    unique case (state_q)
      StIdle:   push_req = enabled_in && is_paged;
      StReplay: push_req = is_paged;
      default:  push_req = is_paged || is_flushed;
    endcase
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == FullCnt);
  assign pop      = (state_q == StReplay) && !empty && replay_ready_in;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign overflow = push_req && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    restart_issue = 1'b0;
    err_d         = err_q;
    if (overflow) err_d[0] = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (push_req) state_d = StDrain;
      end
      StDrain: begin
        // Wait for the tracker to drain and for the response stream to go quiet.
        if ((outstanding_count_in == 8'd0) && !push_req) state_d = StIssue;
      end
      StIssue: begin
        if (command_credit_in) begin
          restart_issue = 1'b1;
          state_d       = StWait;
        end
      end
      StWait: begin
        if (is_restart_rsp) begin
          if (response_code_in == CodeDone) begin
            state_d = StReplay;
          end else begin
            err_d[1] = 1'b1;
            state_d  = StIssue;
          end
        end
      end
      StReplay: begin
        if (is_paged) state_d = StDrain;
        else if (count_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 2'b00;
      block_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      block_q  <= (state_d != StIdle);
    end
  end

  // Storage needs no reset: the pointers and occupancy define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= response_tag_in;
  end

  assign restart_valid_out   = restart_issue;
  assign restart_command_out = restart_issue ? RESTART_OPCODE : 13'd0;
  assign restart_tag_out     = restart_issue ? RESTART_TAG : 8'd0;
  assign command_block_out   = block_q;
  assign replay_valid_out    = (state_q == StReplay) && !empty;
  assign replay_tag_out      = replay_valid_out ? mem_q[rd_ptr_q] : 8'd0;
  assign restart_error_out   = err_q;

endmodule

// File: tb/tb_restart_control.sv
module tb_restart_control;

  localparam logic [7:0]  RT    = 8'hFF;
  localparam int          DEPTH = 32;
  localparam logic [12:0] OPC   = 13'h0001;
  localparam logic [7:0]  DONE  = 8'h00;
  localparam logic [7:0]  FLUSH = 8'h06;
  localparam logic [7:0]  PAGED = 8'h0A;

  localparam int PhIdle = 0, PhDrain = 1, PhIssue = 2, PhWait = 3, PhReplay = 4;

  logic        clock = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled_in = 1'b0;
  logic        response_valid_in = 1'b0;
  logic [7:0]  response_tag_in = 8'd0;
  logic [7:0]  response_code_in = 8'd0;
  logic [7:0]  outstanding_count_in = 8'd0;
  logic        command_credit_in = 1'b0;
  logic        replay_ready_in = 1'b0;
  logic        restart_valid_out;
  logic [12:0] restart_command_out;
  logic [7:0]  restart_tag_out;
  logic        command_block_out;
  logic        replay_valid_out;
  logic [7:0]  replay_tag_out;
  logic [1:0]  restart_error_out;

  restart_control dut (
    .clock               (clock),
    .rstn                (rstn),
    .enabled_in          (enabled_in),
    .response_valid_in   (response_valid_in),
    .response_tag_in     (response_tag_in),
    .response_code_in    (response_code_in),
    .outstanding_count_in(outstanding_count_in),
    .command_credit_in   (command_credit_in),
    .restart_valid_out   (restart_valid_out),
    .restart_command_out (restart_command_out),
    .restart_tag_out     (restart_tag_out),
    .command_block_out   (command_block_out),
    .replay_valid_out    (replay_valid_out),
    .replay_tag_out      (replay_tag_out),
    .replay_ready_in     (replay_ready_in),
    .restart_error_out   (restart_error_out)
  );

  always #5 clock = ~clock;

  // Behavioural model: phase of the sequence, queue of tags, sticky errors.
  int         ph = PhIdle;
  logic [7:0] mq[$];
  logic [1:0] m_err = 2'b00;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  logic [12:0] last_cmd = 13'd0;
  logic [7:0]  last_rtag = 8'd0;
  logic [7:0]  pops[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] exp_vec();
    logic rv, rpv;
    rv  = (ph == PhIssue) && command_credit_in;
    rpv = (ph == PhReplay) && (mq.size() > 0);
    return {rv, rv ? OPC : 13'd0, rv ? RT : 8'd0, ph != PhIdle, rpv,
            rpv ? mq[0] : 8'd0, m_err};
  endfunction

  function automatic logic [33:0] act_vec();
    return {restart_valid_out, restart_command_out, restart_tag_out, command_block_out,
            replay_valid_out, replay_valid_out ? replay_tag_out : 8'd0, restart_error_out};
  endfunction

  function automatic logic [47:0] pops_pack();
    logic [47:0] r;
    r = '0;
    r[47:40] = 8'(pops.size());
    for (int i = 0; i < 5 && i < pops.size(); i++) r[39-8*i -: 8] = pops[i];
    return r;
  endfunction

  // Single compare process: every cycle, mid-period, DUT outputs vs model.
  always @(negedge clock) begin
    chk("cycle_outputs", 64'(act_vec()), 64'(exp_vec()));
    if (rstn) begin
      if (restart_valid_out) begin
        pulses++;
        last_cmd  = restart_command_out;
        last_rtag = restart_tag_out;
      end
      if (replay_valid_out && replay_ready_in) pops.push_back(replay_tag_out);
    end
  end

  task automatic model_clear();
    ph = PhIdle;
    mq.delete();
    m_err = 2'b00;
  endtask

  // Apply the rules to the inputs that were present at this rising edge.
  task automatic model_step();
    bit normal, paged, flushed, rrsp, push, pop, full;
    int nph;
    normal  = response_valid_in && (response_tag_in != RT);
    paged   = normal && (response_code_in == PAGED);
    flushed = normal && (response_code_in == FLUSH);
    rrsp    = response_valid_in && (response_tag_in == RT);
    push = 0;
    pop  = 0;
    nph  = ph;
    case (ph)
      PhIdle: if (enabled_in && paged) begin push = 1; nph = PhDrain; end
      PhDrain: begin
        push = paged || flushed;
        if (outstanding_count_in == 0 && !push) nph = PhIssue;
      end
      PhIssue: begin
        push = paged || flushed;
        if (command_credit_in) nph = PhWait;
      end
      PhWait: begin
        push = paged || flushed;
        if (rrsp) begin
          if (response_code_in == DONE) nph = PhReplay;
          else begin m_err[1] = 1'b1; nph = PhIssue; end
        end
      end
      default: begin
        push = paged;
        pop  = (mq.size() > 0) && replay_ready_in;
        if (paged) nph = PhDrain;
      end
    endcase
    full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (full && !pop) m_err[0] = 1'b1;
      else mq.push_back(response_tag_in);
    end
    if (ph == PhReplay && !push && mq.size() == 0) nph = PhIdle;
    ph = nph;
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_in();
    response_valid_in = 1'b0;
    response_tag_in   = 8'd0;
    response_code_in  = 8'd0;
  endtask

  task automatic rsp(input logic [7:0] tag, input logic [7:0] code);
    response_valid_in = 1'b1;
    response_tag_in   = tag;
    response_code_in  = code;
    cyc();
    idle_in();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_clear();
    idle_in();
    repeat (3) @(posedge clock);
    #1;
    rstn = 1'b1;
  endtask

  task automatic wait_pulse(input string name, input int max);
    int p0;
    p0 = pulses;
    for (int i = 0; i < max && pulses == p0; i++) cyc();
    chk(name, 64'(pulses - p0), 64'd1);
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int i = 0; i < max && command_block_out; i++) cyc();
    chk(name, 64'(command_block_out), 64'd0);
  endtask

  initial begin
    int p0;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    enabled_in = 1'b1;
    command_credit_in = 1'b1;
    replay_ready_in = 1'b1;
    outstanding_count_in = 8'd1;
    do_reset();
    chk("reset_outputs", 64'(act_vec()), 64'd0);

    // Basic sequence: PAGED 3, FLUSHED 5, 7.
    pops.delete();
    p0 = pulses;
    rsp(8'd3, PAGED);
    chk("block_after_paged", 64'(command_block_out), 64'd1);
    rsp(8'd5, FLUSH);
    rsp(8'd7, FLUSH);
    outstanding_count_in = 8'd0;
    wait_pulse("s1_pulse", 20);
    chk("s1_cmd", 64'(last_cmd), 64'h0001);
    chk("s1_rtag", 64'(last_rtag), 64'hFF);
    rsp(RT, DONE);
    wait_idle("s1_idle", 50);
    chk("s1_replay_order", 64'(pops_pack()), 64'({8'd3, 8'd3, 8'd5, 8'd7, 8'd0, 8'd0}));
    chk("s1_one_pulse", 64'(pulses - p0), 64'd1);

    // Credit starvation, then a failed RESTART and a retry.
    pops.delete();
    command_credit_in = 1'b0;
    rsp(8'd9, PAGED);
    p0 = pulses;
    repeat (11) cyc();
    chk("credit_held_no_pulse", 64'(pulses - p0), 64'd0);
    command_credit_in = 1'b1;
    cyc();
    chk("pulse_on_credit", 64'(pulses - p0), 64'd1);
    rsp(RT, 8'h01);
    chk("err_bad_restart", 64'(restart_error_out), 64'd2);
    wait_pulse("retry_pulse", 10);
    rsp(RT, DONE);
    wait_idle("s2_idle", 50);
    chk("s2_replay", 64'(pops_pack()), 64'({8'd1, 8'd9, 32'd0}));
    chk("s2_err_sticky", 64'(restart_error_out), 64'd2);

    // Ready toggling with a PAGED arriving on a pop cycle during replay.
    do_reset();
    pops.delete();
    replay_ready_in = 1'b0;
    outstanding_count_in = 8'd1;
    rsp(8'd10, PAGED);
    rsp(8'd11, FLUSH);
    rsp(8'd12, FLUSH);
    outstanding_count_in = 8'd0;
    wait_pulse("s3_pulse", 20);
    rsp(RT, DONE);
    replay_ready_in = 1'b1;
    cyc();
    replay_ready_in = 1'b0;
    cyc();
    replay_ready_in = 1'b1;
    rsp(8'd50, PAGED);
    chk("s3_redrain_no_replay", 64'(replay_valid_out), 64'd0);
    wait_pulse("s3_pulse2", 20);
    rsp(RT, DONE);
    for (int i = 0; i < 60 && command_block_out; i++) begin
      replay_ready_in = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("s3_idle", 64'(command_block_out), 64'd0);
    chk("s3_replay", 64'(pops_pack()), 64'({8'd4, 8'd10, 8'd11, 8'd12, 8'd50, 8'd0}));
    replay_ready_in = 1'b1;

    // Overflow: 33 pushes into 32 entries.
    do_reset();
    pops.delete();
    outstanding_count_in = 8'd1;
    rsp(8'd0, PAGED);
    for (int i = 1; i <= 32; i++) rsp(8'(i), FLUSH);
    chk("overflow_flag", 64'(restart_error_out), 64'd1);
    outstanding_count_in = 8'd0;
    wait_pulse("s4_pulse", 20);
    rsp(RT, DONE);
    wait_idle("s4_idle", 100);
    chk("s4_count", 64'(pops.size()), 64'd32);
    if (pops.size() == 32) chk("s4_ends", 64'({pops[0], pops[31]}), 64'h001F);

    // Reset while waiting for the RESTART answer with 4 tags queued.
    do_reset();
    pops.delete();
    outstanding_count_in = 8'd1;
    rsp(8'd20, PAGED);
    rsp(8'd21, FLUSH);
    rsp(8'd22, FLUSH);
    rsp(8'd23, FLUSH);
    outstanding_count_in = 8'd0;
    wait_pulse("s5_pulse", 20);
    #2;
    rstn = 1'b0;
    model_clear();
    #1;
    chk("async_reset_outputs", 64'(act_vec()), 64'd0);
    @(posedge clock);
    #1;
    rstn = 1'b1;
    rsp(RT, DONE);
    repeat (10) cyc();
    chk("s5_no_replay", 64'(pops.size()), 64'd0);
    chk("s5_block_low", 64'(command_block_out), 64'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      enabled_in = ($urandom_range(0, 9) != 0);
      outstanding_count_in = $urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(1, 3));
      command_credit_in = ($urandom_range(0, 3) != 0);
      replay_ready_in = ($urandom_range(0, 2) != 0);
      if (ph == PhWait && $urandom_range(0, 3) == 0) begin
        response_valid_in = 1'b1;
        response_tag_in = RT;
        response_code_in = ($urandom_range(0, 4) == 0) ? 8'h01 : DONE;
      end else begin
        response_valid_in = ($urandom_range(0, 2) == 0);
        response_tag_in = ($urandom_range(0, 15) == 0) ? RT : 8'($urandom_range(0, 254));
        case ($urandom_range(0, 3))
          0: response_code_in = DONE;
          1: response_code_in = FLUSH;
          2: response_code_in = PAGED;
          default: response_code_in = 8'($urandom_range(0, 255));
        endcase
      end
      cyc();
    end
    idle_in();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
